// File: rtl/imm_narrower.sv
// rtl/imm_narrower.sv - narrow a 32-bit value to a 16-bit immediate through a 2-entry elastic buffer
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   upstream holds a value
//   in_ready   block can accept this cycle (registered state only)
//   in_ext     32-bit value to narrow
//   in_signed  1 = signed range check/saturate, 0 = unsigned
//   in_sat     1 = saturate on overflow, 0 = wrap (truncate)
//   out_valid  head entry available
//   out_ready  downstream accepts the head entry
//   out_imm    narrowed 16-bit value of the head entry
//   out_fits   head entry was representable in the selected mode
//   clr_count  synchronous clear of ovf_count
//   ovf_count  saturating count of accepted values that did not fit

module imm_narrower #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ext,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm,
  output logic             out_fits,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  // Each entry is {fits, imm}.
  logic [16:0] mem0, mem1;
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic        accept, pop;
  logic        fits_s, fits_u, fits;
  logic [15:0] sat_val, imm_n;
  logic [16:0] head;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head     = rd_ptr ? mem1 : mem0;
  assign out_imm  = head[15:0];
  assign out_fits = head[16];

  // A signed 16-bit value needs bits 31..15 to all equal the sign bit.
  always_comb begin
    fits_s  = (&in_ext[31:15]) | ~(|in_ext[31:15]);
    fits_u  = ~(|in_ext[31:16]);
    fits    = in_signed ? fits_s : fits_u;
    sat_val = in_signed ? (in_ext[31] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
    imm_n   = in_ext[15:0];
    if (!fits && in_sat) begin
      imm_n = sat_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem0   <= 17'h0;
      mem1   <= 17'h0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) begin
        if (wr_ptr) begin
          mem1 <= {fits, imm_n};
        end else begin
          mem0 <= {fits, imm_n};
        end
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Clear has priority over a same-cycle increment; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= '0;
    end else if (accept && !fits && !(&ovf_count)) begin
      ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
